// File: rtl/turn_sched_pkg.sv
// Shared types and constants for the keypad game turn scheduler.
package game_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TURN   = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } sched_state_t;

    localparam logic [3:0] KEY_START     = 4'hA;
    localparam logic [3:0] KEY_CLEAR     = 4'hB;
    localparam logic [3:0] CODE_TIMEOUT  = 4'hF;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= KEY_DIGIT_MAX);
    endfunction

endpackage

// File: rtl/turn_sched_if.sv
// Keypad event inputs and move/game status outputs of the turn scheduler.
interface turn_sched_if #(
    parameter int TW = 27,
    parameter int RW = 4
) ();
    logic [3:0]    key_code;
    logic          key_valid;
    logic          en;
    logic          whose;
    logic          move_valid;
    logic [3:0]    move_code;
    logic          move_timeout;
    logic [TW-1:0] remain;
    logic [RW-1:0] round;
    logic          game_over;
    logic [1:0]    winner;

    modport master (
        output key_code, key_valid,
        input  en, whose, move_valid, move_code, move_timeout,
        input  remain, round, game_over, winner
    );

    modport slave (
        input  key_code, key_valid,
        output en, whose, move_valid, move_code, move_timeout,
        output remain, round, game_over, winner
    );
endinterface

// File: rtl/turn_timer.sv
// Loadable per-turn down-counter; stops at zero and flags expiry while running.
module turn_timer #(
    parameter int TW = 27
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          run,
    output logic [TW-1:0] remain,
    output logic          expired
);

    logic [TW-1:0] remain_r;

    // Countdown register: load has priority, otherwise decrement while running and nonzero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            remain_r <= {TW{1'b0}};
        end else if (load) begin
            remain_r <= load_val;
        end else if (run && (remain_r != {TW{1'b0}})) begin
            remain_r <= remain_r - TW'(1);
        end else begin
            remain_r <= remain_r;
        end
    end

    assign remain  = remain_r;
    assign expired = run && (remain_r == {TW{1'b0}});

endmodule

// File: rtl/turn_sched.sv
// Two-player turn scheduler: start/abort handling, per-turn timeout, move commit,
// strike and round bookkeeping, and end-of-game decision.
module turn_sched
    import game_pkg::*;
#(
    parameter int TURN_TICKS  = 100_000_000,
    parameter int TW          = 27,
    parameter int MAX_ROUNDS  = 8,
    parameter int RW          = 4,
    parameter int MAX_STRIKES = 3
) (
    input logic         clk,
    input logic         rst,
    turn_sched_if.slave bus
);

    localparam int            SW         = $clog2(MAX_STRIKES + 1);
    localparam logic [TW-1:0] TICKS_LAST = TW'(TURN_TICKS - 1);

    sched_state_t  state_r, state_next_s;
    logic          whose_r;
    logic [RW-1:0] round_r;
    logic [SW-1:0] strikes_r [2];
    logic [1:0]    winner_r;
    logic [3:0]    move_code_r;
    logic          move_timeout_r;
    logic          en_r, move_valid_r, game_over_r;

    logic          load_s, run_s, expired_s;
    logic [TW-1:0] load_val_s, remain_s;
    logic          start_s, to_idle_s, accept_s, expire_s;
    logic          forfeit_s, draw_s, next_turn_s;

    assign run_s = (state_r == S_TURN);

    turn_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .run      (run_s),
        .remain   (remain_s),
        .expired  (expired_s)
    );

    // Next-state decode and event flags; abort beats a key, a key beats expiry.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        load_val_s   = TICKS_LAST;
        start_s      = 1'b0;
        to_idle_s    = 1'b0;
        accept_s     = 1'b0;
        expire_s     = 1'b0;
        forfeit_s    = 1'b0;
        draw_s       = 1'b0;
        next_turn_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.key_valid && (bus.key_code == KEY_START)) begin
                    state_next_s = S_TURN;
                    load_s       = 1'b1;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_TURN: begin
                if (bus.key_valid && (bus.key_code == KEY_CLEAR)) begin
                    state_next_s = S_IDLE;
                    load_s       = 1'b1;
                    load_val_s   = {TW{1'b0}};
                    to_idle_s    = 1'b1;
                end else if (bus.key_valid && is_digit(bus.key_code)) begin
                    state_next_s = S_COMMIT;
                    accept_s     = 1'b1;
                end else if (expired_s) begin
                    state_next_s = S_COMMIT;
                    expire_s     = 1'b1;
                end else begin
                    state_next_s = S_TURN;
                end
            end
            S_COMMIT: begin
                if (strikes_r[whose_r] == SW'(MAX_STRIKES)) begin
                    state_next_s = S_DONE;
                    load_s       = 1'b1;
                    load_val_s   = {TW{1'b0}};
                    forfeit_s    = 1'b1;
                end else if (whose_r && ((round_r + RW'(1)) == RW'(MAX_ROUNDS))) begin
                    state_next_s = S_DONE;
                    load_s       = 1'b1;
                    load_val_s   = {TW{1'b0}};
                    draw_s       = 1'b1;
                end else begin
                    state_next_s = S_TURN;
                    load_s       = 1'b1;
                    next_turn_s  = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.key_valid && (bus.key_code == KEY_CLEAR)) begin
                    state_next_s = S_IDLE;
                    to_idle_s    = 1'b1;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
                load_s       = 1'b1;
                load_val_s   = {TW{1'b0}};
                to_idle_s    = 1'b1;
            end
        endcase
    end

    // State register, game bookkeeping and registered outputs; entering IDLE zeroes everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= S_IDLE;
            whose_r        <= 1'b0;
            round_r        <= {RW{1'b0}};
            strikes_r[0]   <= {SW{1'b0}};
            strikes_r[1]   <= {SW{1'b0}};
            winner_r       <= WIN_NONE;
            move_code_r    <= 4'h0;
            move_timeout_r <= 1'b0;
            en_r           <= 1'b0;
            move_valid_r   <= 1'b0;
            game_over_r    <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            en_r         <= (state_next_s == S_TURN);
            move_valid_r <= (state_next_s == S_COMMIT);
            game_over_r  <= (state_next_s == S_DONE);
            if (start_s || to_idle_s) begin
                whose_r        <= 1'b0;
                round_r        <= {RW{1'b0}};
                strikes_r[0]   <= {SW{1'b0}};
                strikes_r[1]   <= {SW{1'b0}};
                winner_r       <= WIN_NONE;
                move_code_r    <= 4'h0;
                move_timeout_r <= 1'b0;
            end else begin
                if (accept_s) begin
                    move_code_r    <= bus.key_code;
                    move_timeout_r <= 1'b0;
                end else if (expire_s) begin
                    move_code_r    <= CODE_TIMEOUT;
                    move_timeout_r <= 1'b1;
                    if (strikes_r[whose_r] < SW'(MAX_STRIKES)) begin
                        strikes_r[whose_r] <= strikes_r[whose_r] + SW'(1);
                    end
                end
                if (forfeit_s) begin
                    winner_r <= whose_r ? WIN_P0 : WIN_P1;
                end else if (draw_s) begin
                    round_r  <= round_r + RW'(1);
                    winner_r <= WIN_DRAW;
                end else if (next_turn_s) begin
                    whose_r <= ~whose_r;
                    if (whose_r) begin
                        round_r <= round_r + RW'(1);
                    end
                end
            end
        end
    end

    assign bus.en           = en_r;
    assign bus.whose        = whose_r;
    assign bus.move_valid   = move_valid_r;
    assign bus.move_code    = move_code_r;
    assign bus.move_timeout = move_timeout_r;
    assign bus.remain       = remain_s;
    assign bus.round        = round_r;
    assign bus.game_over    = game_over_r;
    assign bus.winner       = winner_r;

endmodule

// File: tb/tb_turn_sched.sv
// Directed bench for turn_sched: instance A (10-tick turns, 2 rounds) and
// instance B (4-tick turns, 4 rounds) for the timeout/forfeit scenario.
module tb_turn_sched;
    import game_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   n;

    turn_sched_if #(.TW(4), .RW(3)) a_if ();
    turn_sched_if #(.TW(4), .RW(3)) b_if ();

    turn_sched #(.TURN_TICKS(10), .TW(4), .MAX_ROUNDS(2), .RW(3), .MAX_STRIKES(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    turn_sched #(.TURN_TICKS(4), .TW(4), .MAX_ROUNDS(4), .RW(3), .MAX_STRIKES(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic key_a(input logic [3:0] c);
        a_if.key_code  = c;
        a_if.key_valid = 1'b1;
        step();
        a_if.key_valid = 1'b0;
        a_if.key_code  = 4'h0;
    endtask

    task automatic key_b(input logic [3:0] c);
        b_if.key_code  = c;
        b_if.key_valid = 1'b1;
        step();
        b_if.key_valid = 1'b0;
        b_if.key_code  = 4'h0;
    endtask

    function automatic logic [31:0] outs_a();
        return 32'({a_if.en, a_if.whose, a_if.move_valid, a_if.move_code, a_if.move_timeout,
                    a_if.remain, a_if.round, a_if.game_over, a_if.winner});
    endfunction

    function automatic logic [31:0] outs_b();
        return 32'({b_if.en, b_if.whose, b_if.move_valid, b_if.move_code, b_if.move_timeout,
                    b_if.remain, b_if.round, b_if.game_over, b_if.winner});
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        a_if.key_code = 4'h0; a_if.key_valid = 1'b0;
        b_if.key_code = 4'h0; b_if.key_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        chk("reset_a_zero", outs_a(), 32'd0);
        chk("reset_b_zero", outs_b(), 32'd0);

        // Digit in IDLE is ignored
        key_a(4'd3);
        chk("idle_digit_ignored", outs_a(), 32'd0);

        // Normal turn
        key_a(KEY_START);
        chk("start_en", 32'(a_if.en), 32'd1);
        chk("start_remain", 32'(a_if.remain), 32'd9);
        step();
        step();
        key_a(KEY_START);
        chk("turn_star_remain", 32'(a_if.remain), 32'd6);
        chk("turn_star_no_move", 32'(a_if.move_valid), 32'd0);
        key_a(4'd5);
        chk("commit_valid", 32'(a_if.move_valid), 32'd1);
        chk("commit_code", 32'(a_if.move_code), 32'd5);
        chk("commit_timeout", 32'(a_if.move_timeout), 32'd0);
        chk("commit_whose", 32'(a_if.whose), 32'd0);
        chk("commit_en_low", 32'(a_if.en), 32'd0);
        key_a(4'd8);
        chk("next_turn_whose", 32'(a_if.whose), 32'd1);
        chk("next_turn_remain", 32'(a_if.remain), 32'd9);
        chk("next_turn_en", 32'(a_if.en), 32'd1);
        chk("commit_key_ignored_code", 32'(a_if.move_code), 32'd5);
        chk("single_pulse", 32'(a_if.move_valid), 32'd0);

        // Key arriving in the expiry cycle wins
        for (int i = 0; i < 9; i++) step();
        chk("expiry_cycle_remain", 32'(a_if.remain), 32'd0);
        key_a(4'd7);
        chk("race_valid", 32'(a_if.move_valid), 32'd1);
        chk("race_code", 32'(a_if.move_code), 32'd7);
        chk("race_timeout", 32'(a_if.move_timeout), 32'd0);
        chk("race_strikes_p1", 32'(dut_a.strikes_r[1]), 32'd0);
        step();
        chk("round_after_p1", 32'(a_if.round), 32'd1);
        chk("whose_after_p1", 32'(a_if.whose), 32'd0);

        // Round exhaustion
        key_a(4'd1);
        step();
        key_a(4'd2);
        chk("fourth_commit_code", 32'(a_if.move_code), 32'd2);
        step();
        chk("draw_game_over", 32'(a_if.game_over), 32'd1);
        chk("draw_round", 32'(a_if.round), 32'd2);
        chk("draw_winner", 32'(a_if.winner), 32'(WIN_DRAW));
        chk("draw_en_low", 32'(a_if.en), 32'd0);
        key_a(4'd5);
        chk("done_key_ignored", 32'({a_if.game_over, a_if.winner}), 32'h7);
        key_a(KEY_CLEAR);
        chk("done_clear_zero", outs_a(), 32'd0);

        // Abort during a turn
        key_a(KEY_START);
        step();
        key_a(KEY_CLEAR);
        chk("abort_zero", outs_a(), 32'd0);
        step();
        chk("abort_no_move", 32'(a_if.move_valid), 32'd0);

        // Reset while in COMMIT
        key_a(KEY_START);
        key_a(4'd4);
        chk("pre_reset_valid", 32'(a_if.move_valid), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("commit_reset_zero", outs_a(), 32'd0);
        step();
        chk("post_reset_idle", outs_a(), 32'd0);

        // Timeouts and forfeit on instance B
        key_b(KEY_START);
        for (int t = 0; t < 5; t++) begin
            n = 0;
            while (b_if.en === 1'b1 && n < 20) begin
                n++;
                step();
            end
            chk("tmo_en_cycles", 32'(n), 32'd4);
            chk("tmo_valid", 32'(b_if.move_valid), 32'd1);
            chk("tmo_code", 32'(b_if.move_code), 32'(CODE_TIMEOUT));
            chk("tmo_flag", 32'(b_if.move_timeout), 32'd1);
            chk("tmo_whose", 32'(b_if.whose), 32'(t % 2));
            step();
        end
        chk("forfeit_game_over", 32'(b_if.game_over), 32'd1);
        chk("forfeit_winner", 32'(b_if.winner), 32'(WIN_P1));
        chk("forfeit_round", 32'(b_if.round), 32'd2);
        chk("forfeit_en_low", 32'(b_if.en), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/turn_sched.md
# turn_sched

Two-player turn scheduler for the keypad game. It consumes decoded keypad events, decides whose turn it is, and runs a per-turn timeout. It issues one commit pulse per move and ends the game on round exhaustion or too many timeouts. Its `en` output gates the shared counter and random generator, so they run only during an active turn.

## Interface
Parameters:
- `TURN_TICKS`, default 100_000_000: clock cycles allowed per turn (1 s at 100 MHz).
- `TW`, default 27: timer width; must satisfy 2^TW > TURN_TICKS.
- `MAX_ROUNDS`, default 8: rounds per game; one round is player 0 then player 1.
- `RW`, default 4: round counter width; must satisfy 2^RW > MAX_ROUNDS.
- `MAX_STRIKES`, default 3: timeouts that forfeit the game.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-low.
- `key_code` in 4: decoded key. 0–9 are digits, 4'hA is `*` (start), 4'hB is `#` (abort/clear).
- `key_valid` in 1: one-cycle strobe; `key_code` is valid when high.
- `en` out 1: high only in TURN; gates the counter and random generator.
- `whose` out 1: current player (0 or 1).
- `move_valid` out 1: one-cycle commit strobe.
- `move_code` out 4: committed digit, or 4'hF on timeout. Valid with `move_valid`.
- `move_timeout` out 1: high with `move_valid` when the move was a timeout.
- `remain` out TW: ticks left in the current turn.
- `round` out RW: completed rounds.
- `game_over` out 1: high in DONE.
- `winner` out 2: 00 none, 01 player 0, 10 player 1, 11 rounds exhausted (draw; scoring is external).

## Operation
- States: IDLE, TURN, COMMIT, DONE.
- **IDLE:**
  - All outputs are 0.
  - `key_valid` with `*` sets `whose` to 0, `round` to 0 and both strike counters to 0, loads `remain` with TURN_TICKS-1, then goes to TURN.
  - All other keys are ignored.
- **TURN:**
  - `en` is 1 and `remain` decrements by 1 per cycle.
  - `key_valid` with a digit latches `move_code` = digit, `move_timeout` = 0, then goes to COMMIT.
  - `remain` == 0 with no accepted key latches `move_code` = 4'hF, `move_timeout` = 1, increments the current player's strike counter, then goes to COMMIT.
  - `key_valid` with `#` goes to IDLE with no commit.
  - `*` is ignored in this state.
- **COMMIT (one cycle):**
  - `move_valid` = 1 and `en` = 0.
  - Next state, highest priority first:
    1. If the current player's strikes == MAX_STRIKES: `winner` = the other player, go to DONE.
    2. Else if `whose` == 1 and `round`+1 == MAX_ROUNDS: increment `round`, `winner` = 11, go to DONE.
    3. Otherwise: toggle `whose`, increment `round` if `whose` was 1, reload `remain`, go to TURN.
  - All keys are ignored in COMMIT.
- **DONE:**
  - `game_over` = 1; `winner` and `round` hold.
  - `#` goes to IDLE and clears `winner`.
  - All other keys are ignored.
- `round` never exceeds MAX_ROUNDS. Strike counters saturate at MAX_STRIKES.

## Timing
- Reset: `rst` sampled low at a rising edge forces IDLE, `whose`=0, `remain`=0, `round`=0, strikes=0, `winner`=00. All outputs are 0 from the cycle after that edge. This applies from any state, including mid-COMMIT; a pending `move_valid` is dropped.
- Key latency: `key_valid` at edge n in TURN gives `move_valid` high for cycle n+1. The next turn starts at n+2 with `en`=1 and `remain`=TURN_TICKS-1.
- Timeout: a turn lasts exactly TURN_TICKS cycles in TURN. The last TURN cycle shows `remain`=0, and `move_valid` follows in the next cycle.
- Key and expiry in the same cycle: the key wins. No strike is counted and `move_timeout`=0.
- `#` and expiry in the same cycle: abort wins.
- `en` drops in the COMMIT cycle, so downstream logic sees a one-cycle gap between turns.
- `move_code` and `move_timeout` hold their values until the next commit.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.

## Structure
- Package `game_pkg` holds:
  - state enum `sched_state_t`;
  - key constants `KEY_START`=4'hA, `KEY_CLEAR`=4'hB, `CODE_TIMEOUT`=4'hF;
  - winner encodings `WIN_NONE`, `WIN_P0`, `WIN_P1`, `WIN_DRAW`.
- Sub-module `turn_timer`:
  - loadable down-counter of width TW;
  - ports: `load`, `run`, `remain`, and an `expired` flag that is high when `remain`==0 while running.
- The FSM, strike counters, round counter and output registers live in `turn_sched`.

## Test plan
1. **Normal turn.** TURN_TICKS=10, MAX_ROUNDS=2. Press `*`, then digit 5 after 3 cycles.
   - `move_valid` pulses once with `move_code`=5, `whose`=0.
   - `whose` becomes 1 two cycles after the key, with `remain`=9.
2. **Timeouts and forfeit.** TURN_TICKS=4, MAX_STRIKES=3. Start the game and press no keys.
   - Each turn is exactly 4 `en` cycles followed by a `move_valid` with `move_code`=4'hF and `move_timeout`=1.
   - After player 0's third timeout: DONE with `winner`=10.
3. **Round exhaustion.** MAX_ROUNDS=2. Both players answer on every turn.
   - After the 4th commit: `game_over`=1, `round`=2, `winner`=11.
   - `#` then returns to IDLE with all outputs 0.
4. **Simultaneous key and expiry.** Assert digit 7 in the cycle where `remain`=0.
   - `move_code`=7, `move_timeout`=0, strike count unchanged.
5. **Abort and mid-operation reset.**
   - `#` during TURN returns to IDLE with no `move_valid`.
   - Driving `rst` low during COMMIT suppresses `move_valid` in the following cycle; all outputs are 0 and the state is IDLE.
6. **Ignored keys.** A `*` during TURN, any key during COMMIT, and a digit during IDLE change no outputs.
